// File: rtl/alu_stim_checker.sv
// Transaction driver and checker for the 4-bit three-phase (IDLE/EXEC/WB) ALU.
// Issues operands aligned to the ALU phase and scores registered results against a golden model.
`timescale 1ns/1ps
module alu_stim_checker #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [15:0] SEED_DEF = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] txn_count,
    input  logic [15:0]      seed,
    input  logic             dir_en,
    input  logic [3:0]       dir_a,
    input  logic [3:0]       dir_b,
    input  logic [1:0]       dir_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [3:0]       result_i,
    input  logic             carry_i,
    input  logic             zero_i,
    input  logic             overflow_i,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [2:0] {StIdle, StAlign, StRun, StDrain, StDone} state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [1:0]       ph_q;
    logic [15:0]      lfsr_q, lfsr_next;
    logic [CNT_W-1:0] count_q, issued_q, checked_q, mismatch_q, first_err_q;
    logic             dir_q, err_q, chk_pend_q;
    logic [6:0]       exp_q;
    logic [3:0]       a_q, b_q;
    logic [1:0]       op_q;

    logic ph_wb, ph_cmp, more_txn;
    logic run_start, load_ops, wb_capture, do_cmp;

    // Result packed as {r[3:0], carry, zero, overflow}, matching the compare order.
    function automatic logic [6:0] golden(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
        logic [4:0] r;
        logic       c, v;
        r = 5'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin
                r = {1'b0, a} + {1'b0, b};
                c = r[4];
                v = (a[3] == b[3]) && (a[3] != r[3]);
            end
            2'b01: begin
                r = {1'b0, a} - {1'b0, b};
                c = r[4];
                v = (a[3] != b[3]) && (a[3] != r[3]);
            end
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return {r[3:0], c, (r[3:0] == 4'd0), v};
    endfunction

    assign ph_wb     = (ph_q == 2'd2);
    assign ph_cmp    = (ph_q == 2'd0);
    assign more_txn  = (issued_q < count_q);
    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = (txn_count == '0) ? StDone : StAlign;
            StAlign: if (ph_wb) state_d = StRun;
            StRun:   if (ph_wb && !more_txn) state_d = StDrain;
            StDrain: if (ph_cmp && chk_pend_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q == StAlign) || (state_q == StRun) || (state_q == StDrain);
        done       = (state_q == StDone);
        run_start  = (state_q == StIdle) && start;
        load_ops   = ph_wb && ((state_q == StAlign) || ((state_q == StRun) && more_txn));
        wb_capture = ph_wb && (state_q == StRun);
        do_cmp     = ph_cmp && chk_pend_q && ((state_q == StRun) || (state_q == StDrain));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q        <= 2'd0;
            lfsr_q      <= SEED_DEF;
            count_q     <= '0;
            issued_q    <= '0;
            checked_q   <= '0;
            mismatch_q  <= '0;
            first_err_q <= '0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            chk_pend_q  <= 1'b0;
            exp_q       <= 7'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            op_q        <= 2'd0;
        end else begin
            ph_q <= ph_wb ? 2'd0 : ph_q + 2'd1;

            if (run_start) begin
                count_q     <= txn_count;
                dir_q       <= dir_en;
                lfsr_q      <= (seed == 16'd0) ? SEED_DEF : seed;
                err_q       <= 1'b0;
                mismatch_q  <= '0;
                first_err_q <= '0;
                issued_q    <= '0;
                checked_q   <= '0;
                chk_pend_q  <= 1'b0;
            end

            if (load_ops) begin
                if (dir_q) begin
                    {op_q, b_q, a_q} <= {dir_op, dir_b, dir_a};
                end else begin
                    {op_q, b_q, a_q} <= lfsr_q[9:0];
                    lfsr_q           <= lfsr_next;
                end
                issued_q <= issued_q + CntOne;
            end

            // Expected value is taken on the same edge the ALU writes back.
            if (wb_capture) begin
                exp_q      <= golden(a_q, b_q, op_q);
                chk_pend_q <= 1'b1;
            end

            if (do_cmp) begin
                if ({result_i, carry_i, zero_i, overflow_i} != exp_q) begin
                    if (mismatch_q != '1) mismatch_q <= mismatch_q + CntOne;
                    if (!err_q) first_err_q <= checked_q;
                    err_q <= 1'b1;
                end
                checked_q  <= checked_q + CntOne;
                chk_pend_q <= 1'b0;
            end
        end
    end

    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_op        = op_q;
    assign err_flag      = err_q;
    assign mismatch_cnt  = mismatch_q;
    assign first_err_idx = first_err_q;

endmodule
